// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the RV32I core sharing one instruction/data memory.
// Walks FETCH/DECODE/EXEC/MEM/WB, drives every datapath enable/select and counts retirements.
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             BrEq,
  input  logic             BrLt,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             IRWEn,
  output logic             ALUOutWEn,
  output logic             PCWEn,
  output logic             PCsel,
  output logic             RegWEn,
  output logic [2:0]       Immsel,
  output logic             Asel,
  output logic             Bsel,
  output logic             BrUn,
  output logic [3:0]       ALU_sel,
  output logic [1:0]       WBsel,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_tmo_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             r_trap;
  logic [1:0]       r_cause;
  logic [1:0]       w_set_cause;
  logic [4:0]       w_opc;
  logic             w_opc_ok;
  logic             w_legal;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_is_branch;
  logic             w_is_jump;
  logic             w_taken;
  logic             w_tmo_last;
  logic [2:0]       w_imm_sel;
  logic             w_a_sel;
  logic             w_b_sel;
  logic [3:0]       w_alu_sel;
  logic             w_unused;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  alu_decode = (is_r && alt) ? 4'b0001 : 4'b0000;
      3'b001:  alu_decode = 4'b0010;
      3'b010:  alu_decode = 4'b0011;
      3'b011:  alu_decode = 4'b0100;
      3'b100:  alu_decode = 4'b0101;
      3'b101:  alu_decode = alt ? 4'b0111 : 4'b0110;
      3'b110:  alu_decode = 4'b1000;
      3'b111:  alu_decode = 4'b1001;
      default: alu_decode = 4'b0000;
    endcase
  endfunction

  function automatic logic branch_taken(input logic f14, input logic f12, input logic eq, input logic lt);
    case ({f14, f12})
      2'b00:   branch_taken = eq;
      2'b01:   branch_taken = !eq;
      2'b10:   branch_taken = lt;
      2'b11:   branch_taken = !lt;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  assign w_opc       = instruction[6:2];
  assign w_legal     = w_opc_ok & (instruction[1:0] == 2'b11);
  assign w_is_load   = (w_opc == OP_LOAD);
  assign w_is_store  = (w_opc == OP_STORE);
  assign w_is_branch = (w_opc == OP_BRANCH);
  assign w_is_jump   = (w_opc == OP_JAL) || (w_opc == OP_JALR);
  assign w_taken     = branch_taken(instruction[14], instruction[12], BrEq, BrLt);
  assign w_tmo_last  = (r_tmo_cnt == TMO_LAST);
  assign w_unused    = ^{instruction[31], instruction[29:15], instruction[11:7]};

  assign state        = r_state;
  assign retire_count = r_retire_cnt;
  assign trap         = r_trap;
  assign trap_cause   = r_cause;

  // Opcode legality and the EXEC-phase datapath selects.
  always_comb begin
    w_opc_ok  = 1'b1;
    w_imm_sel = 3'b000;
    w_a_sel   = 1'b0;
    w_b_sel   = 1'b1;
    w_alu_sel = 4'b0000;
    case (w_opc)
      OP_R: begin
        w_b_sel   = 1'b0;
        w_alu_sel = alu_decode(instruction[14:12], instruction[30], 1'b1);
      end
      OP_I: begin
        w_imm_sel = 3'b001;
        w_alu_sel = alu_decode(instruction[14:12], instruction[30], 1'b0);
      end
      OP_LOAD:   w_imm_sel = 3'b001;
      OP_STORE:  w_imm_sel = 3'b010;
      OP_BRANCH: w_a_sel   = 1'b1;
      OP_JAL: begin
        w_imm_sel = 3'b100;
        w_a_sel   = 1'b1;
      end
      OP_JALR:   w_imm_sel = 3'b001;
      OP_AUIPC: begin
        w_imm_sel = 3'b011;
        w_a_sel   = 1'b1;
      end
      OP_LUI: begin
        w_imm_sel = 3'b011;
        w_alu_sel = 4'b1010;
      end
      default: begin
        w_opc_ok = 1'b0;
        w_b_sel  = 1'b0;
      end
    endcase
  end

  // Next-state and control-output decode.
  always_comb begin
    w_next       = r_state;
    w_set_cause  = 2'b00;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    IRWEn        = 1'b0;
    ALUOutWEn    = 1'b0;
    PCWEn        = 1'b0;
    PCsel        = 1'b0;
    RegWEn       = 1'b0;
    Immsel       = 3'b000;
    Asel         = 1'b0;
    Bsel         = 1'b0;
    BrUn         = 1'b0;
    ALU_sel      = 4'b0000;
    WBsel        = 2'b00;
    retire       = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          IRWEn  = 1'b1;
          w_next = S_DECODE;
        end else if (w_tmo_last) begin
          w_next      = S_TRAP;
          w_set_cause = 2'b10;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next      = S_TRAP;
          w_set_cause = 2'b01;
        end
      end
      S_EXEC: begin
        Immsel  = w_imm_sel;
        Asel    = w_a_sel;
        Bsel    = w_b_sel;
        ALU_sel = w_alu_sel;
        if (w_is_branch) begin
          BrUn   = instruction[13];
          PCWEn  = 1'b1;
          PCsel  = w_taken;
          retire = 1'b1;
          w_next = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          ALUOutWEn = 1'b1;
          w_next    = S_MEM;
        end else begin
          ALUOutWEn = 1'b1;
          w_next    = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = w_is_store;
        if (mem_ack) begin
          if (w_is_store) begin
            PCWEn  = 1'b1;
            retire = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_tmo_last) begin
          w_next      = S_TRAP;
          w_set_cause = 2'b10;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        RegWEn = 1'b1;
        WBsel  = w_is_load ? 2'b00 : (w_is_jump ? 2'b10 : 2'b01);
        PCWEn  = 1'b1;
        PCsel  = w_is_jump;
        retire = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_IDLE;
    endcase
  end

  // State, memory-wait counter, retire counter and sticky trap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tmo_cnt    <= 16'd0;
      r_retire_cnt <= '0;
      r_trap       <= 1'b0;
      r_cause      <= 2'b00;
    end else begin
      r_state <= w_next;
      // Only a stall (staying in FETCH/MEM) advances the wait count; any entry clears it.
      if (((r_state == S_FETCH) || (r_state == S_MEM)) && (w_next == r_state)) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end else begin
        r_tmo_cnt <= 16'd0;
      end
      if (retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
      if ((w_set_cause != 2'b00) && !r_trap) begin
        r_trap  <= 1'b1;
        r_cause <= w_set_cause;
      end
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer against a phase-plan reference model.
module tb_mc_sequencer;

  localparam int TMO = 4;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_TRAP = 6;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6,
                 K_AUIPC = 7, K_LUI = 8, K_ILL = 9;

  typedef struct {
    int ph;
    bit ack;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        BrEq = 1'b0, BrLt = 1'b0, mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, IRWEn, ALUOutWEn, PCWEn, PCsel, RegWEn;
  logic [2:0]  Immsel;
  logic        Asel, Bsel, BrUn;
  logic [3:0]  ALU_sel;
  logic [1:0]  WBsel;
  logic        retire;
  logic [3:0]  retire_count;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
  logic [30:0] obs;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [3:0]  m_cnt = 4'd0;

  mc_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .BrEq(BrEq), .BrLt(BrLt),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .IRWEn(IRWEn), .ALUOutWEn(ALUOutWEn), .PCWEn(PCWEn), .PCsel(PCsel), .RegWEn(RegWEn),
    .Immsel(Immsel), .Asel(Asel), .Bsel(Bsel), .BrUn(BrUn), .ALU_sel(ALU_sel), .WBsel(WBsel),
    .retire(retire), .retire_count(retire_count), .trap(trap), .trap_cause(trap_cause),
    .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, mem_req, mem_we, mem_addr_sel, IRWEn, ALUOutWEn, PCWEn, PCsel, RegWEn,
                Immsel, Asel, Bsel, BrUn, ALU_sel, WBsel, retire, trap, trap_cause, retire_count};

  function automatic int kind_of(input logic [31:0] ins);
    if (ins[1:0] != 2'b11) return K_ILL;
    case (ins[6:2])
      5'b01100: return K_R;
      5'b00100: return K_I;
      5'b00000: return K_LD;
      5'b01000: return K_ST;
      5'b11000: return K_BR;
      5'b11011: return K_JAL;
      5'b11001: return K_JALR;
      5'b00101: return K_AUIPC;
      5'b01101: return K_LUI;
      default:  return K_ILL;
    endcase
  endfunction

  // Expected control word for one cycle of a given phase, from the instruction's class.
  function automatic logic [26:0] exp_vec(input int ph, input logic [31:0] ins, input bit ack,
                                          input bit breq, input bit brlt, input logic [1:0] tc);
    int k;
    logic [2:0] f3, imm;
    logic req, we, adr, irw, aluw, pcw, pcs, rw, e_a, e_b, bu, ret, trp;
    logic [3:0] alu;
    logic [1:0] wb, cs;
    logic [3:0] alu_tbl [8];
    alu_tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    {req, we, adr, irw, aluw, pcw, pcs, rw, e_a, e_b, bu, ret, trp} = 13'd0;
    imm = 3'd0; alu = 4'd0; wb = 2'd0; cs = 2'd0;
    k = kind_of(ins);
    f3 = ins[14:12];
    case (ph)
      P_FETCH: begin req = 1'b1; irw = ack; end
      P_EXEC: begin
        case (k)
          K_I, K_LD, K_JALR: imm = 3'd1;
          K_ST:              imm = 3'd2;
          K_AUIPC, K_LUI:    imm = 3'd3;
          K_JAL:             imm = 3'd4;
          default:           imm = 3'd0;
        endcase
        e_a = (k == K_BR) || (k == K_JAL) || (k == K_AUIPC);
        e_b = (k != K_R);
        if (k == K_LUI) alu = 4'd10;
        else if (k == K_R || k == K_I) begin
          alu = alu_tbl[f3];
          if (f3 == 3'd5 && ins[30]) alu = 4'd7;
          if (f3 == 3'd0 && ins[30] && k == K_R) alu = 4'd1;
        end
        if (k == K_BR) begin
          bu = ins[13]; pcw = 1'b1; ret = 1'b1;
          case (f3)
            3'd0:       pcs = breq;
            3'd1:       pcs = !breq;
            3'd4, 3'd6: pcs = brlt;
            default:    pcs = !brlt;
          endcase
        end else aluw = 1'b1;
      end
      P_MEM: begin
        req = 1'b1; adr = 1'b1; we = (k == K_ST);
        if (ack && k == K_ST) begin pcw = 1'b1; ret = 1'b1; end
      end
      P_WB: begin
        rw = 1'b1; pcw = 1'b1; ret = 1'b1;
        pcs = (k == K_JAL) || (k == K_JALR);
        wb = (k == K_LD) ? 2'd0 : (pcs ? 2'd2 : 2'd1);
      end
      P_TRAP: begin trp = 1'b1; cs = tc; end
      default: ;
    endcase
    return {3'(ph), req, we, adr, irw, aluw, pcw, pcs, rw, imm, e_a, e_b, bu, alu, wb, ret, trp, cs};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    r[1:0] = 2'b11;
    case ($urandom_range(0, 8))
      0: r[6:2] = 5'b01100;
      1: r[6:2] = 5'b00100;
      2: r[6:2] = 5'b00000;
      3: r[6:2] = 5'b01000;
      4: r[6:2] = 5'b11000;
      5: r[6:2] = 5'b11011;
      6: r[6:2] = 5'b11001;
      7: r[6:2] = 5'b00101;
      default: r[6:2] = 5'b01101;
    endcase
    if (r[6:2] == 5'b11000 && r[14:13] == 2'b01) r[14] = 1'b1;
    return r;
  endfunction

  // Hold reset, check the all-zero reset/IDLE outputs, then release.
  task automatic do_reset();
    rst_n = 1'b0; mem_ack = 1'b0; instruction = 32'd0; m_cnt = 4'd0;
    repeat (2) begin
      @(negedge clk); #1;
      n_chk++;
      if (obs !== 31'd0) begin n_fail++; $display("FAIL reset: got %h expected 0", obs); end
    end
    @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1; #1;
    n_chk++;
    if (obs !== 31'd0) begin n_fail++; $display("FAIL idle: got %h expected 0", obs); end
  endtask

  // Plan the phases one instruction should visit, drive it, and compare every cycle.
  task automatic do_instr(input logic [31:0] ins, input int fd, input int md, input bit breq, input bit brlt);
    step_t plan[$];
    int k;
    logic [1:0] tc;
    logic [30:0] exp;
    k = kind_of(ins);
    tc = 2'b00;
    for (int i = 0; i < fd && i < TMO; i++) plan.push_back('{P_FETCH, 1'b0});
    if (fd >= TMO) tc = 2'b10;
    else begin
      plan.push_back('{P_FETCH, 1'b1});
      plan.push_back('{P_DEC, 1'($urandom)});
      if (k == K_ILL) tc = 2'b01;
      else begin
        plan.push_back('{P_EXEC, 1'($urandom)});
        if (k == K_LD || k == K_ST) begin
          for (int i = 0; i < md && i < TMO; i++) plan.push_back('{P_MEM, 1'b0});
          if (md >= TMO) tc = 2'b10;
          else begin
            plan.push_back('{P_MEM, 1'b1});
            if (k == K_LD) plan.push_back('{P_WB, 1'($urandom)});
          end
        end else if (k != K_BR) plan.push_back('{P_WB, 1'($urandom)});
      end
    end
    if (tc != 2'b00) repeat (20) plan.push_back('{P_TRAP, 1'($urandom)});
    foreach (plan[i]) begin
      @(negedge clk);
      instruction = ins; mem_ack = plan[i].ack; BrEq = breq; BrLt = brlt;
      #1;
      exp = {exp_vec(plan[i].ph, ins, plan[i].ack, breq, brlt, tc), m_cnt};
      n_chk++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL ctrl ins=%h phase=%0d: got %h expected %h", ins, plan[i].ph, obs, exp);
      end
      if (exp[7]) m_cnt = m_cnt + 4'd1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); mem_ack = 1'b0; #1;
    n_chk++;
    if (obs !== {exp_vec(P_FETCH, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00), 4'd0}) begin
      n_fail++; $display("FAIL fetch_req: got %h", obs);
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== 31'd0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", obs); end
    do_reset();
  endtask

  task automatic test_directed();
    do_reset();
    do_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
    do_instr(32'h0000A183, 3, 3, 1'b0, 1'b0);
    do_instr(32'h00208063, 0, 0, 1'b1, 1'b0);
    do_instr(32'h00208063, 1, 0, 1'b0, 1'b1);
    do_instr(32'h0020E063, 0, 0, 1'b0, 1'b1);
    do_instr(32'h008000EF, 2, 0, 1'b0, 1'b0);
    do_instr(32'h0020A023, 1, 2, 1'b0, 1'b0);
    do_instr(32'h4020D1B3, 0, 0, 1'b0, 1'b0);
    do_instr(32'h123451B7, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 60; n++)
      do_instr(rand_instr(), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1),
               1'($urandom), 1'($urandom));
  endtask

  task automatic test_illegal();
    do_reset();
    do_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);
    do_reset();
    do_instr(32'h002081B1, 1, 0, 1'b0, 1'b0);
    do_reset();
  endtask

  task automatic test_timeout();
    do_reset();
    do_instr(32'h002081B3, TMO, 0, 1'b0, 1'b0);
    do_reset();
    do_instr(32'h002081B3, TMO - 1, 0, 1'b0, 1'b0);
    do_instr(32'h0000A183, 0, TMO, 1'b0, 1'b0);
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (16) do_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
    @(negedge clk); mem_ack = 1'b0; #1;
    n_chk++;
    if (retire_count !== 4'd0) begin
      n_fail++; $display("FAIL wrap: got %0d expected 0", retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_timeout();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
